// File: rtl/csr_resp_pkg.sv
// Shared types and address defaults for the CSR access responder.
package csr_resp_pkg;

    localparam int unsigned CSR_ADDR_W = 12;
    localparam int unsigned CSR_DATA_W = 32;
    localparam int unsigned PRIV_W     = 2;

    localparam logic [CSR_ADDR_W-1:0] DEF_BASE_ADDR = 12'h064;
    localparam logic [CSR_ADDR_W-1:0] DEF_VCNT_ADDR = 12'hF64;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_lvl_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_PRIV     = 2'b01,
        CAUSE_RO_WRITE = 2'b10,
        CAUSE_UNMAPPED = 2'b11
    } csr_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CHECK = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

    // Request fields captured on the accept edge
    typedef struct packed {
        logic                  we;
        logic                  read;
        logic [CSR_ADDR_W-1:0] addr;
        logic [CSR_DATA_W-1:0] wdata;
        logic [PRIV_W-1:0]     priv;
    } csr_req_t;

endpackage

// File: rtl/csr_priv_checker.sv
// Combinational CSR access rule; also used by the core-side check.
module csr_priv_checker
    import csr_resp_pkg::*;
(
    input  logic [CSR_ADDR_W-1:0] addr_i,
    input  logic                  we_i,
    input  logic [PRIV_W-1:0]     priv_i,
    input  logic                  is_bank_i,
    input  logic                  is_vcnt_i,
    output logic                  exception_o,
    output csr_cause_e            cause_o
);

    logic              mapped;
    logic [PRIV_W-1:0] req_priv;

    // First matching fault wins: unmapped, then privilege, then read-only write
    always_comb begin
        mapped      = is_bank_i | is_vcnt_i;
        req_priv    = mapped ? PRIV_W'(PRIV_M) : addr_i[9:8];
        exception_o = 1'b0;
        cause_o     = CAUSE_NONE;
        if (!mapped) begin
            exception_o = 1'b1;
            cause_o     = CAUSE_UNMAPPED;
        end else if (priv_i < req_priv) begin
            exception_o = 1'b1;
            cause_o     = CAUSE_PRIV;
        end else if (we_i && (addr_i[11:10] == 2'b11)) begin
            exception_o = 1'b1;
            cause_o     = CAUSE_RO_WRITE;
        end
    end

endmodule

// File: rtl/csr_access_responder.sv
// Protected CSR bank plus saturating violation counter behind a req/rsp handshake.
module csr_access_responder
    import csr_resp_pkg::*;
#(
    parameter int unsigned           NUM_REGS  = 4,
    parameter logic [CSR_ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [CSR_ADDR_W-1:0] VCNT_ADDR = DEF_VCNT_ADDR,
    parameter int unsigned           CNT_W     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic                  req_read_i,
    input  logic [CSR_ADDR_W-1:0] req_addr_i,
    input  logic [CSR_DATA_W-1:0] req_wdata_i,
    input  logic [PRIV_W-1:0]     priv_lvl_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [CSR_DATA_W-1:0] rsp_rdata_o,
    output logic                  rsp_exception_o,
    output logic [1:0]            rsp_cause_o
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_e                state_q, state_d;
    csr_req_t              req_q, req_d;
    logic [CSR_DATA_W-1:0] bank_q [NUM_REGS];
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [CSR_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_exc_q, rsp_exc_d;
    csr_cause_e            rsp_cause_q, rsp_cause_d;

    logic [CSR_ADDR_W-1:0] offs;
    logic [IDX_W-1:0]      bank_idx;
    logic                  is_bank;
    logic                  is_vcnt;
    logic                  chk_exc;
    csr_cause_e            chk_cause;
    logic                  bank_we;
    logic [CSR_DATA_W-1:0] bank_rdata;

    // Address decode of the latched request; offset wraps at 12 bits
    always_comb begin
        offs       = req_q.addr - BASE_ADDR;
        is_bank    = (offs < CSR_ADDR_W'(NUM_REGS));
        is_vcnt    = (req_q.addr == VCNT_ADDR);
        bank_idx   = offs[IDX_W-1:0];
        bank_rdata = bank_q[bank_idx];
    end

    csr_priv_checker u_priv_checker (
        .addr_i      (req_q.addr),
        .we_i        (req_q.we),
        .priv_i      (req_q.priv),
        .is_bank_i   (is_bank),
        .is_vcnt_i   (is_vcnt),
        .exception_o (chk_exc),
        .cause_o     (chk_cause)
    );

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: accept, check, hold response until consumed
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid_i && req_ready_q) state_d = ST_CHECK;
            ST_CHECK: state_d = ST_RESP;
            ST_RESP:  if (rsp_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: request latch, access evaluation, counter and response loading
    always_comb begin
        req_d       = req_q;
        cnt_d       = cnt_q;
        bank_we     = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_exc_d   = rsp_exc_q;
        rsp_cause_d = rsp_cause_q;
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    req_d.we    = req_we_i;
                    req_d.read  = req_read_i;
                    req_d.addr  = req_addr_i;
                    req_d.wdata = req_wdata_i;
                    req_d.priv  = priv_lvl_i;
                end
            end
            ST_CHECK: begin
                rsp_rdata_d = '0;
                rsp_exc_d   = 1'b0;
                rsp_cause_d = CAUSE_NONE;
                // A request with neither we nor read is a no-op with no fault
                if (req_q.we || req_q.read) begin
                    if (chk_exc) begin
                        rsp_exc_d   = 1'b1;
                        rsp_cause_d = chk_cause;
                        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        if (req_q.read) begin
                            rsp_rdata_d = is_bank ? bank_rdata : CSR_DATA_W'(cnt_q);
                        end
                        bank_we = req_q.we & is_bank;
                    end
                end
            end
            default: ;
        endcase
    end

    // Request latch, counter and response registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q       <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_exc_q   <= 1'b0;
            rsp_cause_q <= CAUSE_NONE;
        end else begin
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_exc_q   <= rsp_exc_d;
            rsp_cause_q <= rsp_cause_d;
        end
    end

    // Register bank, written only from CHECK
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NUM_REGS); i++) bank_q[i] <= '0;
        end else if (bank_we) begin
            bank_q[bank_idx] <= req_q.wdata;
        end
    end

    assign req_ready_o     = req_ready_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_rdata_o     = rsp_rdata_q;
    assign rsp_exception_o = rsp_exc_q;
    assign rsp_cause_o     = rsp_cause_q;

endmodule

// File: tb/tb_csr_access_responder.sv
// Bench for csr_access_responder: directed table, handshake corner cases, random vs model.
module tb_csr_access_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_we_i, req_read_i, rsp_ready_i;
    logic [11:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [1:0]  priv_lvl_i;

    logic        req_ready_o, rsp_valid_o, rsp_exception_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_cause_o;
    logic        req_ready2, rsp_valid2, rsp_exc2;
    logic [31:0] rsp_rdata2;
    logic [1:0]  rsp_cause2;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_bank [4];
    int          m_faults;

    always #5 clk_i = ~clk_i;

    csr_access_responder u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_read_i(req_read_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .priv_lvl_i(priv_lvl_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_exception_o(rsp_exception_o), .rsp_cause_o(rsp_cause_o)
    );

    csr_access_responder #(.CNT_W(2)) u_dut2 (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready2),
        .req_we_i(req_we_i), .req_read_i(req_read_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .priv_lvl_i(priv_lvl_i),
        .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata2), .rsp_exception_o(rsp_exc2), .rsp_cause_o(rsp_cause2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_bank[i] = '0;
        m_faults = 0;
    endfunction

    // Reference: the access rules applied to an address map and a fault tally
    function automatic void model(input logic we, input logic rd, input logic [11:0] addr,
                                  input logic [31:0] wd, input logic [1:0] pv,
                                  output logic [31:0] r8, output logic [31:0] r2,
                                  output logic exc, output logic [1:0] cause);
        int a    = int'(addr);
        bit bank = (a >= 'h064) && (a < 'h068);
        bit vcnt = (a == 'hF64);
        r8 = '0; r2 = '0; exc = 1'b0; cause = 2'd0;
        if (!we && !rd) return;
        if (!(bank || vcnt))          cause = 2'd3;
        else if (pv < 2'd3)           cause = 2'd1;
        else if (we && a >= 'hC00)    cause = 2'd2;
        if (cause != 2'd0) begin
            exc = 1'b1;
            m_faults++;
            return;
        end
        if (rd) begin
            if (bank) begin
                r8 = m_bank[a - 'h064];
                r2 = r8;
            end else begin
                r8 = (m_faults > 255) ? 32'd255 : 32'(m_faults);
                r2 = (m_faults > 3)   ? 32'd3   : 32'(m_faults);
            end
        end
        if (we && bank) m_bank[a - 'h064] = wd;
    endfunction

    // Wait for ready, present one request for one accept edge; starts and ends at a negedge
    task automatic send(input logic we, input logic rd, input logic [11:0] addr,
                        input logic [31:0] wd, input logic [1:0] pv);
        int t = 0;
        while (!req_ready_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        if (!req_ready_o) check("req_ready_timeout", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1; req_we_i = we; req_read_i = rd;
        req_addr_i = addr; req_wdata_i = wd; priv_lvl_i = pv;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    // Wait for rsp_valid after the accept edge; two negedges is the expected latency
    task automatic wait_rsp();
        int lat = 1;
        while (!rsp_valid_o && lat < 10) begin
            @(negedge clk_i);
            lat++;
        end
        check("rsp_latency", 32'(lat), 32'd2);
    endtask

    task automatic handshake();
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        check("post_hs_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("post_hs_req_ready", 32'(req_ready_o), 32'd1);
    endtask

    // Full transaction checked against the model on both counter widths
    task automatic txn(input logic we, input logic rd, input logic [11:0] addr,
                       input logic [31:0] wd, input logic [1:0] pv, input int stall,
                       output logic [31:0] g_rd, output logic g_exc, output logic [1:0] g_cause);
        logic [31:0] e8, e2;
        logic        ee;
        logic [1:0]  ec;
        model(we, rd, addr, wd, pv, e8, e2, ee, ec);
        send(we, rd, addr, wd, pv);
        wait_rsp();
        repeat (stall) @(negedge clk_i);
        if (stall > 0) check("stall_rsp_valid", 32'(rsp_valid_o), 32'd1);
        g_rd = rsp_rdata_o; g_exc = rsp_exception_o; g_cause = rsp_cause_o;
        check($sformatf("rdata@%h", addr), rsp_rdata_o, e8);
        check($sformatf("exc@%h", addr), 32'(rsp_exception_o), 32'(ee));
        check($sformatf("cause@%h", addr), 32'(rsp_cause_o), 32'(ec));
        check($sformatf("rdata_w2@%h", addr), rsp_rdata2, e2);
        check($sformatf("cause_w2@%h", addr), 32'(rsp_cause2), 32'(ec));
        handshake();
    endtask

    typedef struct {
        logic        we;
        logic        rd;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [1:0]  pv;
        logic [31:0] e_rdata;
        logic        e_exc;
        logic [1:0]  e_cause;
    } vec_t;

    vec_t tbl [23];

    initial begin
        logic [31:0] g_rd, hold_rd;
        logic        g_exc;
        logic [1:0]  g_cause;

        tbl[0]  = '{1, 0, 12'h064, 32'hDEADBEEF, 2'd3, 32'h0,        0, 2'd0};
        tbl[1]  = '{0, 1, 12'h064, 32'h0,        2'd3, 32'hDEADBEEF, 0, 2'd0};
        tbl[2]  = '{0, 1, 12'hF64, 32'h0,        2'd3, 32'd0,        0, 2'd0};
        tbl[3]  = '{1, 0, 12'h064, 32'h1,        2'd0, 32'h0,        1, 2'd1};
        tbl[4]  = '{0, 1, 12'h064, 32'h0,        2'd3, 32'hDEADBEEF, 0, 2'd0};
        tbl[5]  = '{0, 1, 12'hF64, 32'h0,        2'd3, 32'd1,        0, 2'd0};
        tbl[6]  = '{1, 0, 12'hF64, 32'h5,        2'd3, 32'h0,        1, 2'd2};
        tbl[7]  = '{0, 1, 12'hF64, 32'h0,        2'd3, 32'd2,        0, 2'd0};
        tbl[8]  = '{0, 1, 12'h100, 32'h0,        2'd3, 32'h0,        1, 2'd3};
        tbl[9]  = '{1, 1, 12'h065, 32'h12345678, 2'd3, 32'h0,        0, 2'd0};
        tbl[10] = '{0, 1, 12'h065, 32'h0,        2'd3, 32'h12345678, 0, 2'd0};
        tbl[11] = '{0, 0, 12'h064, 32'h0,        2'd0, 32'h0,        0, 2'd0};
        tbl[12] = '{0, 1, 12'hF64, 32'h0,        2'd3, 32'd3,        0, 2'd0};
        tbl[13] = '{0, 1, 12'h066, 32'h0,        2'd1, 32'h0,        1, 2'd1};
        tbl[14] = '{0, 1, 12'h068, 32'h0,        2'd3, 32'h0,        1, 2'd3};
        tbl[15] = '{0, 1, 12'h063, 32'h0,        2'd3, 32'h0,        1, 2'd3};
        tbl[16] = '{0, 1, 12'hF64, 32'h0,        2'd3, 32'd6,        0, 2'd0};
        tbl[17] = '{0, 1, 12'hF64, 32'h0,        2'd2, 32'h0,        1, 2'd1};
        tbl[18] = '{0, 1, 12'hF64, 32'h0,        2'd3, 32'd7,        0, 2'd0};
        tbl[19] = '{1, 0, 12'h067, 32'hCAFEF00D, 2'd3, 32'h0,        0, 2'd0};
        tbl[20] = '{0, 1, 12'h067, 32'h0,        2'd3, 32'hCAFEF00D, 0, 2'd0};
        tbl[21] = '{1, 0, 12'h100, 32'h9,        2'd3, 32'h0,        1, 2'd3};
        tbl[22] = '{0, 1, 12'hF64, 32'h0,        2'd3, 32'd8,        0, 2'd0};

        rst_i = 1'b1;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_read_i = 1'b0;
        req_addr_i = '0; req_wdata_i = '0; priv_lvl_i = '0; rsp_ready_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check("reset_req_ready", 32'(req_ready_o), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("reset_rdata", rsp_rdata_o, 32'd0);
        check("reset_exc", 32'(rsp_exception_o), 32'd0);
        check("reset_cause", 32'(rsp_cause_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Directed table; the saturated narrow counter is checked via the model
        for (int i = 0; i < 23; i++) begin
            txn(tbl[i].we, tbl[i].rd, tbl[i].addr, tbl[i].wd, tbl[i].pv, 0, g_rd, g_exc, g_cause);
            check($sformatf("tbl%0d_rdata", i), g_rd, tbl[i].e_rdata);
            check($sformatf("tbl%0d_exc", i), 32'(g_exc), 32'(tbl[i].e_exc));
            check($sformatf("tbl%0d_cause", i), 32'(g_cause), 32'(tbl[i].e_cause));
        end
        check("narrow_cnt_saturated", rsp_rdata2, 32'd3);

        // Backpressure: response held, stray requests ignored while in RESP
        model(1'b0, 1'b1, 12'h064, 32'h0, 2'd3, hold_rd, g_rd, g_exc, g_cause);
        send(1'b0, 1'b1, 12'h064, 32'h0, 2'd3);
        wait_rsp();
        for (int c = 0; c < 5; c++) begin
            req_valid_i = 1'b1; req_we_i = 1'b1; req_read_i = 1'b1;
            req_addr_i = 12'h064; req_wdata_i = 32'h0BAD0BAD; priv_lvl_i = 2'd3;
            @(negedge clk_i);
            check($sformatf("bp%0d_rdata", c), rsp_rdata_o, hold_rd);
            check($sformatf("bp%0d_rsp_valid", c), 32'(rsp_valid_o), 32'd1);
            check($sformatf("bp%0d_req_ready", c), 32'(req_ready_o), 32'd0);
            check($sformatf("bp%0d_cause", c), 32'(rsp_cause_o), 32'd0);
        end
        req_valid_i = 1'b0;
        handshake();
        txn(1'b0, 1'b1, 12'h064, 32'h0, 2'd3, 0, g_rd, g_exc, g_cause);

        // Reset during the response of a read-modify-write to 0x065
        send(1'b1, 1'b1, 12'h065, 32'hAAAA5555, 2'd3);
        wait_rsp();
        check("pre_rst_rdata", rsp_rdata_o, 32'h12345678);
        rst_i = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rdata", rsp_rdata_o, 32'd0);
        check("rst_exc", 32'(rsp_exception_o), 32'd0);
        check("rst_cause", 32'(rsp_cause_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        txn(1'b0, 1'b1, 12'h065, 32'h0, 2'd3, 0, g_rd, g_exc, g_cause);
        check("post_rst_reg065", g_rd, 32'd0);
        txn(1'b0, 1'b1, 12'hF64, 32'h0, 2'd3, 0, g_rd, g_exc, g_cause);

        // Random traffic against the model
        for (int n = 0; n < 200; n++) begin
            logic [11:0] a;
            int sel = int'($urandom_range(0, 7));
            case (sel)
                0, 1, 2, 3: a = 12'h064 + 12'(sel);
                4:          a = 12'hF64;
                5:          a = 12'h063;
                6:          a = 12'h068;
                default:    a = 12'($urandom);
            endcase
            txn(1'($urandom), 1'($urandom), a, $urandom, 2'($urandom),
                int'($urandom_range(0, 2)), g_rd, g_exc, g_cause);
        end
        txn(1'b0, 1'b1, 12'hF64, 32'h0, 2'd3, 0, g_rd, g_exc, g_cause);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
